// File: rtl/nbp_mem_arbiter_if.sv
// rtl/nbp_mem_arbiter_if.sv - requester, memory and response signals of the NBP read-port arbiter
interface nbp_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 8
);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mem_req_valid;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic                      mem_req_ready;
    logic                      mem_resp_valid;
    logic [DATA_W-1:0]         mem_resp_data;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic [CNT_W-1:0]          outstanding;
    logic                      err_orphan;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data,
        output outstanding, err_orphan
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, mem_req_valid, mem_req_addr, resp_valid, resp_data,
        input  outstanding, err_orphan
    );
endinterface

// File: rtl/nbp_mem_arbiter.sv
// rtl/nbp_mem_arbiter.sv - round-robin NBP read-port arbiter with in-order tag FIFO response routing
module nbp_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    nbp_mem_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              lock_q, lock_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0]  tag_mem_q [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              err_orphan_q, err_orphan_d;

    logic [IDX_W-1:0]  rr_idx;
    logic              rr_hit;
    logic [IDX_W-1:0]  grant;
    logic              grant_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              mem_req_valid;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] grant_addr;

    // Scanning from the far end downward leaves the nearest valid requester to rr_ptr as the winner.
    always_comb begin
        rr_idx = rr_ptr_q;
        rr_hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int cand;
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (bus.req_valid[IDX_W'(cand)]) begin
                rr_idx = IDX_W'(cand);
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == IDX_W'(k)) grant_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
        end
    end

    assign grant         = lock_q ? lock_idx_q : rr_idx;
    assign grant_valid   = lock_q ? bus.req_valid[lock_idx_q] : rr_hit;
    assign fifo_full     = (count_q == CNT_W'(MAX_OUT));
    assign fifo_empty    = (count_q == '0);
    assign mem_req_valid = !rst && grant_valid && !fifo_full;
    assign push          = mem_req_valid && bus.mem_req_ready;
    assign pop           = bus.mem_resp_valid && !fifo_empty;

    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_req_addr  = grant_addr;
    assign bus.req_ready     = push ? (NUM_REQ'(1) << grant) : '0;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.outstanding   = count_q;
    assign bus.err_orphan    = err_orphan_q;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        err_orphan_d = err_orphan_q || (bus.mem_resp_valid && fifo_empty);
        if (push) begin
            rr_ptr_d = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            lock_d   = 1'b0;
        end else if (mem_req_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
        if (pop) begin
            resp_valid_d = NUM_REQ'(1) << tag_mem_q[rd_ptr_q];
            resp_data_d  = bus.mem_resp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            wr_ptr_q     <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q     <= rd_ptr_q + PTR_W'(pop);
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant;
    end

    // A locked requester withdrawing its request would change the address already presented to memory.
    hold_while_locked: assert property (@(posedge clk) disable iff (rst)
        lock_q |-> bus.req_valid[lock_idx_q]);
endmodule

// File: tb/tb_nbp_mem_arbiter.sv
// tb/tb_nbp_mem_arbiter.sv - self-checking bench for nbp_mem_arbiter with a queue-based reference model
module tb_nbp_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int MO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    nbp_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) bus ();

    nbp_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: arbitration pointer, lock and the tag FIFO as a plain queue.
    int           rr_m;
    bit           lock_m;
    int           lk_m;
    int           tagq[$];
    logic [N-1:0] rv_m;
    logic [DW-1:0] rd_m;
    bit           err_m;

    initial begin
        rr_m = 0; lock_m = 0; lk_m = 0; rv_m = '0; rd_m = '0; err_m = 0;
    end

    always @(negedge clk) begin
        bit found;
        int g;
        bit mv;
        bit hs;
        bit full;
        bit empty;
        logic [N-1:0] ready_m;
        found = 0;
        g     = 0;
        full  = (tagq.size() == MO);
        empty = (tagq.size() == 0);
        if (lock_m) begin
            found = 1;
            g     = lk_m;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr_m + k) % N;
                if (!found && bus.req_valid[c]) begin
                    found = 1;
                    g     = c;
                end
            end
        end
        mv      = !rst && found && bus.req_valid[g] && !full;
        hs      = mv && bus.mem_req_ready;
        ready_m = hs ? N'(1 << g) : '0;

        check("m_mem_req_valid", DW'(bus.mem_req_valid), DW'(mv));
        check("m_req_ready", DW'(bus.req_ready), DW'(ready_m));
        if (mv) check("m_mem_req_addr", DW'(bus.mem_req_addr), DW'(bus.req_addr[g*AW +: AW]));
        check("m_resp_valid", DW'(bus.resp_valid), DW'(rv_m));
        check("m_resp_data", bus.resp_data, rd_m);
        check("m_outstanding", DW'(bus.outstanding), DW'(tagq.size()));
        check("m_err_orphan", DW'(bus.err_orphan), DW'(err_m));

        if (rst) begin
            rr_m = 0; lock_m = 0; tagq.delete(); rv_m = '0; rd_m = '0; err_m = 0;
        end else begin
            rv_m = '0;
            if (bus.mem_resp_valid && !empty) begin
                rv_m = N'(1 << tagq.pop_front());
                rd_m = bus.mem_resp_data;
            end
            if (bus.mem_resp_valid && empty) err_m = 1;
            if (hs) begin
                tagq.push_back(g);
                rr_m   = (g + 1) % N;
                lock_m = 0;
            end else if (mv) begin
                lock_m = 1;
                lk_m   = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.mem_resp_data = {16{$urandom}};
            tick();
        end
        bus.mem_resp_valid = 1'b0;
    endtask

    logic [DW-1:0] dval [4];
    logic [N-1:0]  rexp [4];
    int            cnt  [N];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req_valid      = '0;
        bus.req_addr       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        tick();
        bus.req_valid     = 4'b1111;
        bus.mem_req_ready = 1'b1;
        tick();
        #2;
        check("rst_mem_req_valid", DW'(bus.mem_req_valid), '0);
        check("rst_req_ready", DW'(bus.req_ready), '0);
        check("rst_outstanding", DW'(bus.outstanding), '0);
        check("rst_resp_valid", DW'(bus.resp_valid), '0);
        check("rst_err_orphan", DW'(bus.err_orphan), '0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = 32'h100 + 32'(i);

        // single request from requester 2
        bus.req_addr[2*AW +: AW] = 32'h10;
        bus.req_valid = 4'b0100;
        #2;
        check("t1_mem_req_addr", DW'(bus.mem_req_addr), DW'(32'h10));
        check("t1_req_ready", DW'(bus.req_ready), DW'(4'b0100));
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {16{32'hD00DF00D}};
        tick();
        bus.mem_resp_valid = 1'b0;
        #2;
        check("t1_resp_valid", DW'(bus.resp_valid), DW'(4'b0100));
        check("t1_resp_data", bus.resp_data, {16{32'hD00DF00D}});
        check("t1_outstanding", DW'(bus.outstanding), '0);
        tick();

        // fairness under continuous requests
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            bus.req_valid      = 4'b1111;
            bus.mem_resp_valid = (k >= 1);
            bus.mem_resp_data  = DW'(k);
            #2;
            for (int i = 0; i < N; i++) if (bus.req_ready[i]) cnt[i]++;
            tick();
        end
        bus.req_valid = '0;
        bus.mem_resp_data = DW'(400);
        tick();
        bus.mem_resp_valid = 1'b0;
        for (int i = 0; i < N; i++) check($sformatf("t2_share_%0d", i), DW'(cnt[i]), DW'(100));
        #2;
        check("t2_outstanding", DW'(bus.outstanding), '0);
        tick();

        // stall lock holds requester 2 while requester 0 arrives
        bus.req_addr[2*AW +: AW] = 32'h222;
        bus.req_addr[0*AW +: AW] = 32'h111;
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = (k == 0) ? 4'b0100 : 4'b0101;
            #2;
            check("t3_stall_addr", DW'(bus.mem_req_addr), DW'(32'h222));
            check("t3_stall_ready", DW'(bus.req_ready), '0);
            tick();
        end
        bus.mem_req_ready = 1'b1;
        #2;
        check("t3_first_grant", DW'(bus.req_ready), DW'(4'b0100));
        tick();
        bus.req_valid = 4'b0001;
        #2;
        check("t3_second_grant", DW'(bus.req_ready), DW'(4'b0001));
        check("t3_second_addr", DW'(bus.mem_req_addr), DW'(32'h111));
        tick();
        bus.req_valid = '0;
        drain(2);
        tick();

        // tag FIFO full
        bus.req_valid = 4'b0010;
        for (int k = 0; k < MO; k++) tick();
        #2;
        check("t4_outstanding_full", DW'(bus.outstanding), DW'(MO));
        check("t4_full_no_valid", DW'(bus.mem_req_valid), '0);
        bus.mem_resp_valid = 1'b1;
        #1;
        check("t4_pop_cycle_no_valid", DW'(bus.mem_req_valid), '0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #2;
        check("t4_resume_valid", DW'(bus.mem_req_valid), DW'(1'b1));
        check("t4_resume_ready", DW'(bus.req_ready), DW'(4'b0010));
        check("t4_outstanding_7", DW'(bus.outstanding), DW'(7));
        tick();
        bus.req_valid = '0;
        drain(MO);
        tick();

        // response routing for tags 3,1,3,0
        bus.req_valid = 4'b1000; tick();
        bus.req_valid = 4'b0010; tick();
        bus.req_valid = 4'b1000; tick();
        bus.req_valid = 4'b0001; tick();
        bus.req_valid = '0;
        dval[0] = {16{32'hAAAA0001}}; dval[1] = {16{32'hBBBB0002}};
        dval[2] = {16{32'hCCCC0003}}; dval[3] = {16{32'hDDDD0004}};
        rexp[0] = 4'b1000; rexp[1] = 4'b0010; rexp[2] = 4'b1000; rexp[3] = 4'b0001;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = dval[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) bus.mem_resp_data = dval[i+1];
            else bus.mem_resp_valid = 1'b0;
            #2;
            check($sformatf("t5_resp_valid_%0d", i), DW'(bus.resp_valid), DW'(rexp[i]));
            check($sformatf("t5_resp_data_%0d", i), bus.resp_data, dval[i]);
        end
        tick();

        // orphan response, then reset clears state
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;
        #2;
        check("t6_err_orphan", DW'(bus.err_orphan), DW'(1'b1));
        check("t6_no_resp", DW'(bus.resp_valid), '0);
        tick();
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        #2;
        check("t6_rst_err", DW'(bus.err_orphan), '0);
        check("t6_rst_outstanding", DW'(bus.outstanding), '0);
        check("t6_rst_rr_ptr", DW'(bus.req_ready), DW'(4'b0001));
        tick();
        bus.req_valid = '0;
        drain(1);
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
